alu_iter: RTL and testbench

Parametrised successor to the single-cycle ALU. It has a WIDTH-bit datapath plus a flag bit, and adds iterative multiply, divide and remainder operations. Every operation goes through a valid/ready handshake, so the block can sit between issue and writeback in a pipelined core and stall it on multi-cycle operations. Single-cycle logic and shift operations keep the existing flag semantics.

---
 rtl/alu_iter_pkg.sv | 40 ++++
 rtl/alu_iter_muldiv.sv | 71 +++++++
 rtl/alu_iter.sv | 125 ++++++++++++
 tb/tb_alu_iter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_iter_pkg.sv
// rtl/alu_iter_pkg.sv - opcode/state types and per-bit logic helper for alu_iter
package alu_iter_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_NAND = 4'h1,
    OP_OR   = 4'h2,
    OP_XOR  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_SHR  = 4'h6,
    OP_SHL  = 4'h7,
    OP_MULL = 4'h8,
    OP_MULH = 4'h9,
    OP_DIVU = 4'hA,
    OP_REMU = 4'hB
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // Opcodes 8..B run through the shared multiply/divide unit.
  function automatic logic is_iter(input op_e op);
    is_iter = (op[3:2] == 2'b10);
  endfunction

  // Bitwise-op result for one bit position; applied across the full flag+data vector.
  function automatic logic logic_bit(input op_e op, input logic a, input logic b);
    case (op)
      OP_AND:  logic_bit = a & b;
      OP_NAND: logic_bit = ~(a & b);
      OP_OR:   logic_bit = a | b;
      default: logic_bit = a ^ b;
    endcase
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module alu_iter_muldiv
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [WIDTH-1:0]   o_quot,
  output logic [WIDTH-1:0]   o_rem
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic             r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;

  assign w_add   = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_b} : '0);
  assign w_trial = {r_acc, r_sh[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_b};
  // A zero divisor never borrows, which yields all-ones quotient and remainder == dividend.
  assign w_qbit  = ~w_diff[WIDTH];
  assign o_last  = r_busy && (r_cnt == '0);

  assign o_prod  = {r_acc, r_sh};
  assign o_quot  = r_sh;
  assign o_rem   = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_div  <= i_div;
      r_cnt  <= CW'(WIDTH - 1);
      r_acc  <= '0;
      r_sh   <= i_a;
      r_b    <= i_b;
    end else if (r_busy) begin
      if (o_last) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_div) begin
        r_acc <= w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_sh  <= {r_sh[WIDTH-2:0], w_qbit};
      end else begin
        r_acc <= w_add[WIDTH:1];
        r_sh  <= {w_add[0], r_sh[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - handshaked ALU with single-cycle logic/shift and iterative mul/div
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  op_e            op,
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] result,
  output logic           illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_e             r_state;
  state_e             w_next;
  op_e                r_op;
  logic [WIDTH:0]     r_a;
  logic [WIDTH:0]     r_b;
  logic               r_out_valid;
  logic [WIDTH:0]     r_result;
  logic               r_illegal;

  logic               w_accept;
  logic               w_start;
  logic               w_md_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_logic;
  logic [SHW-1:0]     w_shamt;
  logic               w_b_zero;
  logic [WIDTH:0]     w_res;
  logic               w_ill;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_start   = w_accept && is_iter(op);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign illegal   = r_illegal;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_div   (op[1]),
    .i_a     (a[WIDTH-1:0]),
    .i_b     (b[WIDTH-1:0]),
    .o_last  (w_md_last),
    .o_prod  (w_prod),
    .o_quot  (w_quot),
    .o_rem   (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = is_iter(op) ? S_BUSY : S_DONE;
      S_BUSY:  if (w_md_last) w_next = S_DONE;
      S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op <= op;
      r_a  <= a;
      r_b  <= b;
    end
  end

  always_comb begin
    w_sum    = {1'b0, r_a[WIDTH-1:0]} + {1'b0, r_b[WIDTH-1:0]};
    w_diff   = {1'b0, r_a[WIDTH-1:0]} - {1'b0, r_b[WIDTH-1:0]};
    w_shamt  = r_b[SHW-1:0];
    w_b_zero = (r_b[WIDTH-1:0] == '0);
    for (int i = 0; i <= WIDTH; i++) w_logic[i] = logic_bit(r_op, r_a[i], r_b[i]);
    w_res = '0;
    w_ill = 1'b0;
    case (r_op)
      OP_AND, OP_NAND, OP_OR, OP_XOR: w_res = w_logic;
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_diff;
      OP_SHR:  w_res = $unsigned($signed(r_a) >>> w_shamt);
      OP_SHL:  w_res = r_a << w_shamt;
      OP_MULL: w_res = {|w_prod[2*WIDTH-1:WIDTH], w_prod[WIDTH-1:0]};
      OP_MULH: w_res = {1'b0, w_prod[2*WIDTH-1:WIDTH]};
      OP_DIVU: w_res = {w_b_zero, w_quot};
      OP_REMU: w_res = {w_b_zero, w_rem};
      default: w_ill = 1'b1;
    endcase
  end

  // Result is captured one cycle after entering DONE, then held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
    end else if (r_state == S_DONE && !r_out_valid) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_illegal   <= w_ill;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed self-checking bench for alu_iter
module tb_alu_iter;
  import alu_iter_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  op_e          op;
  logic [W:0]   a;
  logic [W:0]   b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic         illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] code, input logic [W:0] va,
                       input logic [W:0] vb);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = op_e'(code);
    a        = va;
    b        = vb;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " early_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] code, input logic [W:0] va,
                     input logic [W:0] vb, input int exp_lat, input logic [W:0] exp_res);
    int lat;
    issue(tag, code, va, vb);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " illegal"}, 32'(illegal), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, " ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic stale;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = OP_AND;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    rst = 1'b0;
    #1;
    check("rel in_ready", 32'(in_ready), 32'd1);

    run("add_carry", 4'h4, 17'h0FFFF, 17'h00001, 1, 17'h10000);
    run("sub_borrow", 4'h5, 17'h00003, 17'h00005, 1, 17'h1FFFE);
    run("and", 4'h0, 17'h1F0F0, 17'h0FF00, 1, 17'h0F000);
    run("nand", 4'h1, 17'h1F0F0, 17'h0FF00, 1, 17'h10FFF);
    run("or", 4'h2, 17'h1F0F0, 17'h0FF00, 1, 17'h1FFF0);
    run("xor", 4'h3, 17'h1F0F0, 17'h0FF00, 1, 17'h10FF0);
    run("shr_fill1", 4'h6, 17'h18000, 17'h00004, 1, 17'h1F800);
    run("shr_fill0", 4'h6, 17'h08000, 17'h00004, 1, 17'h00800);
    run("shr_hibits", 4'h6, 17'h08000, 17'h1FFF4, 1, 17'h00800);
    run("shl", 4'h7, 17'h08000, 17'h00001, 1, 17'h10000);
    run("mull", 4'h8, 17'h01234, 17'h00100, 17, 17'h13400);
    run("mulh", 4'h9, 17'h01234, 17'h00100, 17, 17'h00012);
    run("mull_nohi", 4'h8, 17'h000FF, 17'h10002, 17, 17'h001FE);
    run("divu", 4'hA, 17'h00064, 17'h00007, 17, 17'h0000E);
    run("remu", 4'hB, 17'h00064, 17'h00007, 17, 17'h00002);
    run("divu_aflag", 4'hA, 17'h10064, 17'h00007, 17, 17'h0000E);
    run("divu_zero", 4'hA, 17'h01234, 17'h00000, 17, 17'h1FFFF);
    run("remu_zero", 4'hB, 17'h01234, 17'h00000, 17, 17'h11234);

    // Backpressure on an illegal opcode while another request is held pending.
    issue("bp", 4'hC, 17'h1ABCD, 17'h01234);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd1);
    in_valid = 1'b1;
    op       = OP_ADD;
    a        = 17'h00001;
    b        = 17'h00001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp result", 32'(result), 32'd0);
      check("bp illegal", 32'(illegal), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp valid_drop", 32'(out_valid), 32'd0);
    check("bp ready_back", 32'(in_ready), 32'd1);
    stale = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("bp no_latch", 32'(stale), 32'd0);

    // Reset in the middle of a divide aborts it.
    issue("abort", 4'hA, 17'h01234, 17'h00007);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    stale = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("abort no_stale", 32'(stale), 32'd0);
    run("add_post", 4'h4, 17'h00002, 17'h00003, 1, 17'h00005);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
